// File: rtl/team_select_grid.sv
// Team chooser for the start screen: a wrapping cursor over a ROWS x COLS
// sprite grid, team building with duplicate rejection, undo, confirm and lock,
// plus registered per-pixel overlay signals for the VGA path.
module team_select_grid #(
  parameter int COLS      = 4,
  parameter int ROWS      = 2,
  parameter int TEAM_SIZE = 3,
  parameter int ID_W      = 3,
  parameter int CELL_X0   = 160,
  parameter int CELL_Y0   = 120,
  parameter int PITCH     = 76,
  parameter int SPRITE_W  = 56,
  parameter int ALLOW_DUP = 0,
  localparam int NUM_W    = $clog2(TEAM_SIZE+1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic                      clear,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [ID_W-1:0]           cur_choice,
  output logic [TEAM_SIZE*ID_W-1:0] my_team,
  output logic [NUM_W-1:0]          num_chosen,
  output logic                      done_select,
  output logic                      is_chooser,
  output logic                      is_cell,
  output logic                      in_team,
  output logic [ID_W-1:0]           cell_id,
  output logic [5:0]                cell_off_x,
  output logic [5:0]                cell_off_y
);
  localparam int NCELL = ROWS*COLS;
  localparam logic [7:0] KEY_W = 8'h1A, KEY_S = 8'h16, KEY_A = 8'h04, KEY_D = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28, KEY_BKSP = 8'h2A, KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {SELECT, FULL, LOCKED} state_t;

  state_t                             state_q, state_d;
  logic [ID_W-1:0]                    row_q, row_d, col_q, col_d;
  logic [NUM_W-1:0]                   num_q, num_d;
  logic [TEAM_SIZE-1:0][ID_W-1:0]     team_q, team_d;
  logic [7:0]                         prev_key_q;
  logic                               key_ok, dup;

  assign cur_choice  = ID_W'(row_q*COLS) + col_q;
  assign my_team     = team_q;
  assign num_chosen  = num_q;
  assign done_select = (state_q == LOCKED);
  assign key_ok      = (keycode != 8'h00) && (keycode != prev_key_q);

  // Duplicate check against the filled slots only; stale slots are ignored.
  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < TEAM_SIZE; k++)
      if (NUM_W'(k) < num_q && team_q[k] == cur_choice) dup = 1'b1;
  end

  // Next-state: clear beats any key; one accepted key acts per cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    num_d   = num_q;
    team_d  = team_q;
    if (clear) begin
      state_d = SELECT;
      row_d   = '0;
      col_d   = '0;
      num_d   = '0;
    end else if (key_ok && state_q != LOCKED) begin
      case (keycode)
        KEY_W: row_d = (row_q == '0) ? ID_W'(ROWS-1) : row_q - 1'b1;
        KEY_S: row_d = (row_q == ID_W'(ROWS-1)) ? '0 : row_q + 1'b1;
        KEY_A: col_d = (col_q == '0) ? ID_W'(COLS-1) : col_q - 1'b1;
        KEY_D: col_d = (col_q == ID_W'(COLS-1)) ? '0 : col_q + 1'b1;
        KEY_ENTER:
          if (state_q == SELECT && !(dup && ALLOW_DUP == 0)) begin
            for (int k = 0; k < TEAM_SIZE; k++)
              if (NUM_W'(k) == num_q) team_d[k] = cur_choice;
            num_d = num_q + 1'b1;
            if (num_d == NUM_W'(TEAM_SIZE)) state_d = FULL;
          end
        KEY_BKSP:
          if (num_q != '0) begin
            num_d   = num_q - 1'b1;
            state_d = SELECT;
          end
        KEY_SPACE: if (state_q == FULL) state_d = LOCKED;
        default: ;
      endcase
    end
  end

  // Selection state registers; prev_key tracks the raw keycode every cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= SELECT;
      row_q      <= '0;
      col_q      <= '0;
      num_q      <= '0;
      team_q     <= '0;
      prev_key_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      num_q      <= num_d;
      team_q     <= team_d;
      prev_key_q <= keycode;
    end
  end

  // ---------------- pixel path ----------------
  logic [10:0]                 px, py;
  logic [NCELL-1:0]            hit, brd;
  logic [NCELL-1:0][5:0]       offx, offy;
  logic                        is_cell_d, is_chooser_d, in_team_d;
  logic [ID_W-1:0]             cell_id_d;
  logic [5:0]                  offx_d, offy_d;

  assign px = {1'b0, DrawX};
  assign py = {1'b0, DrawY};

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int          I  = r*COLS + c;
      localparam logic [10:0] L  = 11'(CELL_X0 + c*PITCH);
      localparam logic [10:0] T  = 11'(CELL_Y0 + r*PITCH);
      localparam logic [10:0] BL = L - 11'd1;
      localparam logic [10:0] BT = T - 11'd1;
      localparam logic [10:0] BR = BL + 11'(SPRITE_W + 1);
      localparam logic [10:0] BB = BT + 11'(SPRITE_W + 1);
      assign hit[I]  = (px >= L) && (px < L + 11'(SPRITE_W)) &&
                       (py >= T) && (py < T + 11'(SPRITE_W));
      assign brd[I]  = ((px >= BL) && (px <= BR) && ((py == BT) || (py == BB))) ||
                       ((py >= BT) && (py <= BB) && ((px == BL) || (px == BR)));
      assign offx[I] = 6'(px - L);
      assign offy[I] = 6'(py - T);
    end
  end

  // Cells never overlap, so at most one hit feeds the id/offset mux.
  always_comb begin
    is_cell_d    = 1'b0;
    is_chooser_d = 1'b0;
    in_team_d    = 1'b0;
    cell_id_d    = '0;
    offx_d       = '0;
    offy_d       = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (hit[i]) begin
        is_cell_d = 1'b1;
        cell_id_d = ID_W'(i);
        offx_d    = offx[i];
        offy_d    = offy[i];
      end
      if (brd[i] && ID_W'(i) == cur_choice) is_chooser_d = 1'b1;
    end
    for (int k = 0; k < TEAM_SIZE; k++)
      if (is_cell_d && NUM_W'(k) < num_q && team_q[k] == cell_id_d) in_team_d = 1'b1;
  end

  // One-cycle pixel latency to line up with the sprite RAM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_cell    <= 1'b0;
      is_chooser <= 1'b0;
      in_team    <= 1'b0;
      cell_id    <= '0;
      cell_off_x <= '0;
      cell_off_y <= '0;
    end else begin
      is_cell    <= is_cell_d;
      is_chooser <= is_chooser_d;
      in_team    <= in_team_d;
      cell_id    <= cell_id_d;
      cell_off_x <= offx_d;
      cell_off_y <= offy_d;
    end
  end
endmodule

// File: tb/tb_team_select_grid.sv
// Bench for team_select_grid: directed test-plan steps then random key/pixel
// traffic, all checked against a division-based behavioural model.
module tb_team_select_grid;
  localparam int COLS = 4, ROWS = 2, TS = 3, ID_W = 3;
  localparam int X0 = 160, Y0 = 120, P = 76, SW = 56;
  localparam int NUM_W = $clog2(TS+1);
  localparam logic [7:0] KW = 8'h1A, KS = 8'h16, KA = 8'h04, KD = 8'h07;
  localparam logic [7:0] KE = 8'h28, KB = 8'h2A, KSP = 8'h2C;

  logic              Clk = 1'b0, Reset = 1'b1, clear = 1'b0;
  logic [7:0]        keycode = 8'h00;
  logic [9:0]        DrawX = '0, DrawY = '0;
  logic [ID_W-1:0]   cur_choice, cell_id;
  logic [TS*ID_W-1:0] my_team;
  logic [NUM_W-1:0]  num_chosen;
  logic              done_select, is_chooser, is_cell, in_team;
  logic [5:0]        cell_off_x, cell_off_y;

  team_select_grid dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .clear(clear),
    .DrawX(DrawX), .DrawY(DrawY), .cur_choice(cur_choice), .my_team(my_team),
    .num_chosen(num_chosen), .done_select(done_select), .is_chooser(is_chooser),
    .is_cell(is_cell), .in_team(in_team), .cell_id(cell_id),
    .cell_off_x(cell_off_x), .cell_off_y(cell_off_y));

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  // model state: 0=choosing, 1=team full, 2=locked
  int m_cur, m_n, m_state, m_prev;
  int m_team[TS];
  int e_ic, e_ch, e_it, e_id, e_ox, e_oy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix_model(input int x, input int y);
    int dx, dy, cr, cc, bl, br, bt, bb;
    e_ic = 0; e_ch = 0; e_it = 0; e_id = 0; e_ox = 0; e_oy = 0;
    if (x >= X0 && y >= Y0) begin
      dx = x - X0; dy = y - Y0;
      if (dx / P < COLS && dy / P < ROWS && dx % P < SW && dy % P < SW) begin
        e_ic = 1; e_id = (dy / P) * COLS + dx / P; e_ox = dx % P; e_oy = dy % P;
        for (int j = 0; j < m_n; j++) if (m_team[j] == e_id) e_it = 1;
      end
    end
    cr = m_cur / COLS; cc = m_cur % COLS;
    bl = X0 + cc*P - 1; br = bl + SW + 1;
    bt = Y0 + cr*P - 1; bb = bt + SW + 1;
    if ((x >= bl && x <= br && (y == bt || y == bb)) ||
        (y >= bt && y <= bb && (x == bl || x == br))) e_ch = 1;
  endtask

  task automatic model_key(input int k, input bit clr);
    bit acc, dup;
    int r, c;
    acc = (k != 0) && (k != m_prev);
    m_prev = k;
    if (clr) begin
      m_state = 0; m_n = 0; m_cur = 0;
    end else if (acc && m_state != 2) begin
      r = m_cur / COLS; c = m_cur % COLS;
      case (k)
        KW: r = (r + ROWS - 1) % ROWS;
        KS: r = (r + 1) % ROWS;
        KA: c = (c + COLS - 1) % COLS;
        KD: c = (c + 1) % COLS;
        KE: if (m_state == 0) begin
              dup = 0;
              for (int j = 0; j < m_n; j++) if (m_team[j] == m_cur) dup = 1;
              if (!dup) begin
                m_team[m_n] = m_cur; m_n++;
                if (m_n == TS) m_state = 1;
              end
            end
        KB: if (m_n > 0) begin m_n--; m_state = 0; end
        KSP: if (m_state == 1) m_state = 2;
        default: ;
      endcase
      m_cur = r*COLS + c;
    end
  endtask

  task automatic check_all();
    chk("cur_choice", 32'(cur_choice), m_cur);
    chk("num_chosen", 32'(num_chosen), m_n);
    chk("done_select", 32'(done_select), (m_state == 2) ? 1 : 0);
    for (int k = 0; k < TS; k++) chk("my_team_slot", 32'(my_team[k*ID_W +: ID_W]), m_team[k]);
    chk("is_cell", 32'(is_cell), e_ic);
    chk("is_chooser", 32'(is_chooser), e_ch);
    chk("in_team", 32'(in_team), e_it);
    chk("cell_id", 32'(cell_id), e_id);
    chk("cell_off_x", 32'(cell_off_x), e_ox);
    chk("cell_off_y", 32'(cell_off_y), e_oy);
  endtask

  // Drive one cycle of inputs, predict, clock, compare.
  task automatic step(input logic [7:0] k, input bit clr, input int x, input int y);
    keycode = k; clear = clr; DrawX = 10'(x); DrawY = 10'(y);
    pix_model(x, y);
    model_key(k, clr);
    @(posedge Clk); #1;
    check_all();
  endtask

  task automatic press(input logic [7:0] k);
    step(k, 1'b0, 0, 0);
    step(8'h00, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1; keycode = 8'h00; clear = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    m_cur = 0; m_n = 0; m_state = 0; m_prev = 0;
    for (int k = 0; k < TS; k++) m_team[k] = 0;
    e_ic = 0; e_ch = 0; e_it = 0; e_id = 0; e_ox = 0; e_oy = 0;
    check_all();
    chk("reset_my_team", 32'(my_team), 0);
  endtask

  initial begin
    logic [7:0] keys[10];
    int exp_tap[4];
    logic [7:0] k;
    keys = '{KW, KS, KA, KD, KE, KB, KSP, 8'h00, 8'h00, 8'h55};
    exp_tap = '{1, 2, 3, 0};

    do_reset();

    // tapping D walks the row and wraps
    for (int i = 0; i < 4; i++) begin
      press(KD);
      chk("tap_D", 32'(cur_choice), exp_tap[i]);
    end
    // a held key acts once
    for (int i = 0; i < 10; i++) step(KD, 1'b0, 0, 0);
    step(8'h00, 1'b0, 0, 0);
    chk("hold_D", 32'(cur_choice), 1);

    // vertical and left wrap
    press(KW); chk("wrap_W", 32'(cur_choice), 5);
    press(KS); chk("wrap_S", 32'(cur_choice), 1);
    press(KA); press(KA); chk("wrap_A", 32'(cur_choice), 3);

    // duplicate rejection and undo at cursor 2
    press(KA);
    press(KE); chk("add2_n", 32'(num_chosen), 1); chk("add2_slot", 32'(my_team[ID_W-1:0]), 2);
    press(KE); chk("dup_n", 32'(num_chosen), 1);
    press(KB); chk("undo_n", 32'(num_chosen), 0);
    press(KE); chk("readd_n", 32'(num_chosen), 1); chk("readd_slot", 32'(my_team[ID_W-1:0]), 2);
    press(KB);

    // full team 0,5,7 then lock
    press(KA); press(KA); press(KE);
    press(KS); press(KD); press(KE);
    press(KD); press(KD); press(KE);
    chk("full_n", 32'(num_chosen), 3);
    chk("full_team", 32'(my_team), (7 << 6) | (5 << 3) | 0);
    press(KW); press(KA); press(KA); chk("cur_1", 32'(cur_choice), 1);
    press(KE); chk("full_enter_n", 32'(num_chosen), 3);
    step(KSP, 1'b0, 0, 0); chk("lock_done", 32'(done_select), 1);
    step(8'h00, 1'b0, 0, 0);
    press(KD); press(KB); chk("lock_cur", 32'(cur_choice), 1); chk("lock_n", 32'(num_chosen), 3);
    step(8'h00, 1'b1, 0, 0);
    chk("clear_done", 32'(done_select), 0); chk("clear_n", 32'(num_chosen), 0);
    chk("clear_cur", 32'(cur_choice), 0);

    // pixel path with cursor at 0
    step(8'h00, 1'b0, 159, 119); chk("pix_corner_ch", 32'(is_chooser), 1);
    step(8'h00, 1'b0, 160, 120); chk("pix_c0_cell", 32'(is_cell), 1);
    chk("pix_c0_off", 32'({cell_off_x, cell_off_y}), 0);
    step(8'h00, 1'b0, 291, 175); chk("pix_c1_id", 32'(cell_id), 1);
    chk("pix_c1_off", 32'({cell_off_x, cell_off_y}), (55 << 6) | 55);
    step(8'h00, 1'b0, 216, 150); chk("pix_border_ch", 32'(is_chooser), 1);
    chk("pix_border_cell", 32'(is_cell), 0);
    step(8'h00, 1'b0, 300, 300); chk("pix_off_all", 32'({is_chooser, is_cell, in_team, cell_id}), 0);

    // clear beats a same-cycle ENTER; reset from FULL
    step(KE, 1'b1, 0, 0); chk("prio_clear_n", 32'(num_chosen), 0);
    step(8'h00, 1'b0, 0, 0);
    press(KE); press(KD); press(KE); press(KD); press(KE);
    chk("refull_n", 32'(num_chosen), 3);
    do_reset();

    // random traffic
    for (int it = 0; it < 400; it++) begin
      k = keys[$urandom_range(0, 9)];
      if (k == 8'h55) k = 8'($urandom);
      for (int h = 0, n = $urandom_range(1, 3); h < n; h++)
        step(k, (h == 0) && ($urandom_range(0, 24) == 0), $urandom_range(140, 470),
             $urandom_range(100, 280));
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
